vec_wb_collector: RTL

- Downstream of the 4-lane vector ALU wrapper.
- Each cycle it captures up to four lane result chunks (vdN at bit index regiN) into a VLEN-bit staging buffer.
- When the ALU signals done, it presents the assembled register as a single write request to the vector register file over a valid/ready handshake.
- It frees the ALU for the next instruction once the write is accepted.

---
 rtl/vec_pkg.sv | 19 +
 rtl/vec_wb_lane_merge.sv | 37 +++
 rtl/vec_wb_collector.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared vector unit types: FSM states, op-type codes, SEW decode
package vec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } wb_state_e;

  localparam logic [1:0] OP_VV = 2'd0;
  localparam logic [1:0] OP_VX = 2'd1;
  localparam logic [1:0] OP_VI = 2'd2;

  // SEW in bits for a vsew code; 11 bits so that vsew=7 (1024) does not wrap
  function automatic logic [10:0] sew_width(input logic [2:0] vsew);
    return 11'd8 << vsew;
  endfunction

endpackage

// File: rtl/vec_wb_lane_merge.sv
// rtl/vec_wb_lane_merge.sv - merges one lane chunk into the staging buffer, flags out-of-range chunks
module vec_wb_lane_merge #(
  parameter int VLEN = 128,
  parameter int CW   = 16
) (
  input  logic [VLEN-1:0]        buf_in,
  input  logic [CW-1:0]          chunk,
  input  logic [9:0]             regi,
  input  logic [$clog2(CW):0]    w,
  input  logic                   en,
  output logic [VLEN-1:0]        buf_out,
  output logic                   ovf
);

  logic [CW-1:0]   wmask;
  logic [10:0]     end_idx;
  logic            fits;
  logic [VLEN-1:0] mask_full;
  logic [VLEN-1:0] data_full;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < CW; i++) begin
      if (i < int'(w)) wmask[i] = 1'b1;
    end
  end

  assign end_idx   = 11'(regi) + 11'(w);
  assign fits      = (end_idx <= 11'(VLEN));
  assign mask_full = VLEN'(wmask) << regi;
  assign data_full = VLEN'(chunk & wmask) << regi;

  // A chunk that does not fit is dropped whole; no partial write at the top edge
  assign buf_out = (en && fits) ? ((buf_in & ~mask_full) | (data_full & mask_full)) : buf_in;
  assign ovf     = en && !fits;

endmodule

// File: rtl/vec_wb_collector.sv
// rtl/vec_wb_collector.sv - collects lane result chunks into a VLEN register and writes it back; VEC_WB_MASK_EN adds masked merge
module vec_wb_collector
  import vec_pkg::*;
#(
  parameter int VLEN         = 128,
  parameter int LANE_WIDTH   = 4,
  parameter int NB_LANES_MAX = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [4:0]              vd_addr,
  input  logic [2:0]              vsew,
  input  logic [1:0]              nb_lanes,
  input  logic [NB_LANES_MAX-1:0] lane_run,
  input  logic [63:0]             vd0,
  input  logic [63:0]             vd1,
  input  logic [63:0]             vd2,
  input  logic [63:0]             vd3,
  input  logic [9:0]              regi0,
  input  logic [9:0]              regi1,
  input  logic [9:0]              regi2,
  input  logic [9:0]              regi3,
  input  logic                    lane_done,
`ifdef VEC_WB_MASK_EN
  input  logic [VLEN-1:0]         vmask,
  input  logic                    mask_en,
  input  logic [VLEN-1:0]         vd_old,
`endif
  output logic                    busy,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [4:0]              wr_addr,
  output logic [VLEN-1:0]         wr_data,
  output logic                    ovf_err
);

  localparam int CW = 1 << LANE_WIDTH;
  localparam int WW = LANE_WIDTH + 1;

  wb_state_e       state_q, state_d;
  logic [VLEN-1:0] buf_q;
  logic [4:0]      addr_q;
  logic [2:0]      vsew_q;
  logic [1:0]      nb_lanes_q;
  logic            ovf_q;
  logic [10:0]     sew;
  logic [WW-1:0]   chunk_w;
  logic [VLEN-1:0] buf_init;

  logic [63:0]             vd_arr   [4];
  logic [9:0]              regi_arr [4];
  logic [VLEN-1:0]         stage    [NB_LANES_MAX+1];
  logic [NB_LANES_MAX-1:0] lane_en;
  logic [NB_LANES_MAX-1:0] lane_ovf;
  logic                    unused_vd_hi;

  assign vd_arr   = '{vd0, vd1, vd2, vd3};
  assign regi_arr = '{regi0, regi1, regi2, regi3};
  assign unused_vd_hi = ^{vd0[63:CW], vd1[63:CW], vd2[63:CW], vd3[63:CW]};

  assign sew     = sew_width(vsew_q);
  assign chunk_w = (sew >= 11'(CW)) ? WW'(CW) : WW'(sew);

`ifdef VEC_WB_MASK_EN
  logic mask_en_q;
  assign buf_init = vd_old;
`else
  assign buf_init = '0;
`endif

  // Lanes chain 0 -> 3 so a higher lane overwrites a lower one on overlap
  assign stage[0] = buf_q;
  for (genvar n = 0; n < NB_LANES_MAX; n++) begin : g_lane
    logic mask_ok;
`ifdef VEC_WB_MASK_EN
    logic [9:0] elem;
    assign elem    = regi_arr[n] >> ({1'b0, vsew_q} + 4'd3);
    assign mask_ok = !mask_en_q ||
                     ((elem < 10'(VLEN)) && vmask[elem[$clog2(VLEN)-1:0]]);
`else
    assign mask_ok = 1'b1;
`endif
    assign lane_en[n] = (state_q == ST_COLLECT) && lane_run[n] &&
                        (2'(n) <= nb_lanes_q) && mask_ok;

    vec_wb_lane_merge #(.VLEN(VLEN), .CW(CW)) u_merge (
      .buf_in  (stage[n]),
      .chunk   (vd_arr[n][CW-1:0]),
      .regi    (regi_arr[n]),
      .w       (chunk_w),
      .en      (lane_en[n]),
      .buf_out (stage[n+1]),
      .ovf     (lane_ovf[n])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start)     state_d = ST_COLLECT;
      ST_COLLECT: if (lane_done) state_d = ST_WRITE;
      ST_WRITE:   if (wr_ready)  state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_q      <= '0;
      addr_q     <= '0;
      vsew_q     <= '0;
      nb_lanes_q <= '0;
      ovf_q      <= 1'b0;
`ifdef VEC_WB_MASK_EN
      mask_en_q  <= 1'b0;
`endif
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        buf_q      <= buf_init;
        addr_q     <= vd_addr;
        vsew_q     <= vsew;
        nb_lanes_q <= nb_lanes;
        ovf_q      <= 1'b0;
`ifdef VEC_WB_MASK_EN
        mask_en_q  <= mask_en;
`endif
      end
    end else if (state_q == ST_COLLECT) begin
      buf_q <= stage[NB_LANES_MAX];
      ovf_q <= ovf_q | (|lane_ovf);
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign wr_valid = (state_q == ST_WRITE);
  assign wr_addr  = addr_q;
  assign wr_data  = buf_q;
  assign ovf_err  = ovf_q;

endmodule
